// File: rtl/sram_like_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_pkg
// Description : Shared types and helpers for the SRAM-like bus responder.
//               - SIZE_* encodings of the bus 'size' field
//               - sram_req_t : one queued request (write flag, size, word
//                 index, byte offset, byte strobe, lane-positioned data)
//               - size_to_strb() : byte strobe for a size/offset pair,
//                 all-zero for misaligned or illegal accesses
// Revision    : 1.0 - initial release
// ============================================================================
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Word index is carried at full bus width; the RAM uses only its low bits.
    localparam int IDX_W = 30;

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic [IDX_W-1:0] idx;
        logic [1:0]       off;
        logic [3:0]       strb;
        logic [31:0]      wdata;
    } sram_req_t;

    // A zero strobe marks an access that must not modify memory.
    function automatic logic [3:0] size_to_strb(input logic [1:0] size,
                                                input logic [1:0] off);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << off;
            SIZE_HALF: if (!off[0]) strb = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: if (off == 2'b00) strb = 4'b1111;
            default:   strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_req_fifo
// Description : In-order request queue of sram_req_t entries.
//               Ports:
//                 clk, rst_n      - clock, asynchronous active-low reset
//                 i_push, i_data  - enqueue (ignored when full)
//                 i_pop           - dequeue head (ignored when empty)
//                 o_head          - current head entry
//                 o_full, o_empty - occupancy flags
//                 o_count         - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_req_fifo
    import sram_like_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_push,
    input  sram_req_t                            i_data,
    input  logic                                 i_pop,
    output sram_req_t                            o_head,
    output logic                                 o_full,
    output logic                                 o_empty,
    output logic [$clog2(OUTSTANDING + 1)-1:0]   o_count
);

    localparam int                  c_cnt_w    = $clog2(OUTSTANDING + 1);
    localparam int                  c_ptr_w    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [c_ptr_w-1:0]  c_ptr_last = c_ptr_w'(OUTSTANDING - 1);
    localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(OUTSTANDING);

    sram_req_t          r_mem [OUTSTANDING];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_do_push;
    logic               w_do_pop;
    logic [c_ptr_w-1:0] w_wr_nxt;
    logic [c_ptr_w-1:0] w_rd_nxt;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Explicit wrap keeps non-power-of-two and single-entry depths correct.
    assign w_wr_nxt  = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_nxt  = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= w_wr_nxt;
            if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/sram_like_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_responder
// Description : Responder end of the SRAM-like data bus, backed by an
//               internal word-addressed RAM with fixed response latency and
//               in-order outstanding requests.
//               Ports:
//                 aclk, aresetn - clock, asynchronous active-low reset
//                 req, wr, size, addr, wdata - request channel
//                 addr_ok       - request accepted this cycle (combinational)
//                 data_ok       - one-cycle completion pulse, in order
//                 rdata         - read word, valid with data_ok of a read,
//                                 held between completions
//                 busy          - request queue non-empty
//               Optional build macro SRAM_RESP_RANDOM_DELAY_EN: a 16-bit LFSR
//               adds 0..3 cycles to each head's latency and occasionally
//               masks addr_ok.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int LATENCY     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int               c_cnt_w  = $clog2(OUTSTANDING + 1);
    localparam int               c_lat_w  = 5;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(OUTSTANDING);
    localparam logic [c_lat_w-1:0] c_lat_reload = c_lat_w'(LATENCY - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_lat_w-1:0]   r_cnt;
    logic [c_lat_w-1:0]   w_cnt_nxt;
    logic [c_lat_w-1:0]   w_cnt_load;
    logic [31:0]          r_rdata;
    logic [31:0]          r_ram [2**DEPTH_LOG2];

    sram_req_t            w_push_req;
    sram_req_t            w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_push;
    logic                 w_done;
    logic                 w_gate;
    logic [31:0]          w_ram_rd;
    logic                 w_unused;

`ifdef SRAM_RESP_RANDOM_DELAY_EN
    logic [15:0] r_lfsr;

    // x^16 + x^14 + x^13 + x^11, free-running from a fixed seed.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_lfsr <= 16'hACE1;
        else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_gate     = (r_lfsr[4:2] != 3'b000);
    assign w_cnt_load = c_lat_reload + {3'b000, r_lfsr[1:0]};
`else
    assign w_gate     = 1'b1;
    assign w_cnt_load = c_lat_reload;
`endif

    // No same-cycle bypass: a full queue refuses even while it pops.
    assign addr_ok = aresetn && req && (w_count < c_depth) && w_gate;
    assign w_push  = addr_ok;

    always_comb begin
        w_push_req       = '0;
        w_push_req.wr    = wr;
        w_push_req.size  = size;
        w_push_req.idx   = IDX_W'(addr[DEPTH_LOG2+1:2]);
        w_push_req.off   = addr[1:0];
        w_push_req.strb  = size_to_strb(size, addr[1:0]);
        w_push_req.wdata = wdata;
    end

    sram_like_req_fifo #(
        .OUTSTANDING (OUTSTANDING)
    ) u_req_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_done),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_done   = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_ram_rd = r_ram[w_head.idx[DEPTH_LOG2-1:0]];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = w_cnt_load;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    // Head retires now; keep going if anything remains,
                    // including a request accepted in this same cycle.
                    if ((w_count > c_cnt_w'(1)) || w_push) begin
                        w_cnt_nxt = w_cnt_load;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                 r_rdata <= '0;
        else if (w_done && !w_head.wr) r_rdata <= w_ram_rd;
    end

    // RAM contents survive reset; writes happen only at completion.
    always_ff @(posedge aclk) begin
        if (w_done && w_head.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_head.strb[b]) begin
                    r_ram[w_head.idx[DEPTH_LOG2-1:0]][8*b +: 8] <= w_head.wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_ok = w_done;
    assign rdata   = (w_done && !w_head.wr) ? w_ram_rd : r_rdata;
    assign busy    = !w_empty;

    // Fields kept only for debug visibility, and aliased address bits.
    assign w_unused = ^{w_head.idx, w_head.off, w_head.size, addr, w_full};

endmodule
`default_nettype wire
